// File: rtl/receive_que_slot.sv
// Per-port receive packet buffer: stores whole packets in a byte FIFO, commits on the last byte,
// and offers committed packets one at a time with a quiet gap after each so the handler times out cleanly.
module receive_que_slot #(
  parameter int DEPTH      = 256,
  parameter int GAP_CYCLES = 24
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [7:0]               rx_data,
  input  logic                     rx_data_valid,
  input  logic                     rx_data_last,
  output logic [7:0]               data,
  output logic                     data_enable,
  output logic                     push_enable,
  input  logic                     data_ready,
  output logic                     packet_dropped,
  output logic [$clog2(DEPTH):0]   packet_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_SEND, R_GAP} r_state_t;

  logic [8:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] commit_ptr_reg, commit_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] count_reg, count_next;
  logic [GW-1:0] gap_reg, gap_next;
  w_state_t      w_state_reg, w_state_next;
  r_state_t      r_state_reg, r_state_next;
  logic          full, open_pkt, accept, overflow, commit, read_last;
  logic [8:0]    head;

  // full uses pre-cycle pointers, so a same-cycle read does not free space for this write
  assign full      = (wr_ptr_reg - rd_ptr_reg) == PW'(DEPTH);
  assign open_pkt  = (w_state_reg == W_RECV) || (w_state_reg == W_IDLE && enable);
  assign accept    = rx_data_valid && open_pkt && !full;
  assign overflow  = rx_data_valid && open_pkt && full;
  assign commit    = accept && rx_data_last;
  assign head      = mem[rd_ptr_reg[AW-1:0]];
  assign read_last = (r_state_reg == R_SEND) && data_ready && head[8];

  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr_reg[AW-1:0]] <= {rx_data_last, rx_data};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_state_reg    <= W_IDLE;
      r_state_reg    <= R_IDLE;
      wr_ptr_reg     <= '0;
      commit_ptr_reg <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      gap_reg        <= '0;
    end else begin
      w_state_reg    <= w_state_next;
      r_state_reg    <= r_state_next;
      wr_ptr_reg     <= wr_ptr_next;
      commit_ptr_reg <= commit_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      gap_reg        <= gap_next;
    end
  end

  always_comb begin
    w_state_next    = w_state_reg;
    wr_ptr_next     = wr_ptr_reg;
    commit_ptr_next = commit_ptr_reg;
    case (w_state_reg)
      W_IDLE, W_RECV: begin
        if (accept) begin
          wr_ptr_next = wr_ptr_reg + 1'b1;
          if (rx_data_last) begin
            commit_ptr_next = wr_ptr_reg + 1'b1;
            w_state_next    = W_IDLE;
          end else begin
            w_state_next = W_RECV;
          end
        end else if (overflow) begin
          // rewind over the partial packet; committed data stays untouched
          wr_ptr_next  = commit_ptr_reg;
          w_state_next = rx_data_last ? W_IDLE : W_DROP;
        end else if (w_state_reg == W_IDLE && rx_data_valid && !rx_data_last) begin
          // packet started while disabled: skip the rest of it silently
          w_state_next = W_DROP;
        end
      end
      W_DROP:  if (rx_data_valid && rx_data_last) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_next = r_state_reg;
    rd_ptr_next  = rd_ptr_reg;
    gap_next     = gap_reg;
    case (r_state_reg)
      R_IDLE: if (enable && count_reg != '0) r_state_next = R_SEND;
      R_SEND: begin
        if (data_ready) begin
          rd_ptr_next = rd_ptr_reg + 1'b1;
          if (head[8]) begin
            r_state_next = R_GAP;
            gap_next     = GW'(GAP_CYCLES);
          end
        end
      end
      R_GAP: begin
        gap_next = gap_reg - 1'b1;
        if (gap_reg == GW'(1)) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    if (commit && !read_last)      count_next = count_reg + 1'b1;
    else if (!commit && read_last) count_next = count_reg - 1'b1;
  end

  always_comb begin
    push_enable    = 1'b0;
    data_enable    = 1'b0;
    data           = 8'h00;
    packet_dropped = overflow;
    packet_count   = count_reg;
    case (r_state_reg)
      R_IDLE: push_enable = enable && (count_reg != '0);
      R_SEND: begin
        push_enable = 1'b1;
        data_enable = 1'b1;
        data        = head[7:0];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_receive_que_slot.sv
// Bench for receive_que_slot: directed scenarios plus random traffic, checked every cycle
// against a queue-based packet model with time-stamped read gaps.
module tb_receive_que_slot;
  localparam int DEPTH = 4;
  localparam int GAP   = 24;

  logic       clock, reset_n, enable;
  logic [7:0] rx_data;
  logic       rx_data_valid, rx_data_last;
  logic [7:0] data;
  logic       data_enable, push_enable, data_ready, packet_dropped;
  logic [2:0] packet_count;

  receive_que_slot #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_data_last(rx_data_last),
    .data(data), .data_enable(data_enable), .push_enable(push_enable),
    .data_ready(data_ready), .packet_dropped(packet_dropped), .packet_count(packet_count)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;
  int drops_seen = 0;
  int rdy_pol  = 0;  // 0 never, 1 always, 2 random, 3 left to caller

  // model: committed unread bytes {last,byte}, partial packet bytes, write mode 0 idle/1 recv/2 skip
  logic [8:0] cq[$];
  logic [7:0] pq[$];
  int  wmode, npk, cyc, last_rd;
  bit  sending;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cq.delete(); pq.delete();
    wmode = 0; npk = 0; sending = 0; last_rd = -1000;
  endtask

  function automatic bit m_full();
    return (cq.size() + pq.size()) == DEPTH;
  endfunction

  function automatic bit m_open();
    return (wmode == 1) || (wmode == 0 && enable);
  endfunction

  function automatic bit m_push();
    return sending || ((cyc - last_rd > GAP) && enable && npk != 0);
  endfunction

  task automatic model_update();
    bit full, open, push;
    logic [8:0] e;
    if (!reset_n) begin model_reset(); cyc++; return; end
    full = m_full();
    open = m_open();
    push = m_push();
    if (sending && data_ready) begin
      e = cq.pop_front();
      if (e[8]) begin npk--; sending = 0; last_rd = cyc; end
    end else if (!sending && push) sending = 1;
    if (rx_data_valid) begin
      if (open && !full) begin
        pq.push_back(rx_data);
        if (rx_data_last) begin
          foreach (pq[i]) cq.push_back({(i == pq.size() - 1), pq[i]});
          pq.delete(); npk++; wmode = 0;
        end else wmode = 1;
      end else if (open) begin
        pq.delete(); wmode = rx_data_last ? 0 : 2;
      end else if (wmode == 2) begin
        if (rx_data_last) wmode = 0;
      end else if (!rx_data_last) wmode = 2;
    end
    cyc++;
  endtask

  task automatic tick();
    logic [7:0] exp_data;
    if (rdy_pol == 0) data_ready = 1'b0;
    else if (rdy_pol == 1) data_ready = 1'b1;
    else if (rdy_pol == 2) data_ready = 1'($urandom_range(0, 1));
    #2;
    exp_data = sending ? cq[0][7:0] : 8'h00;
    chk("push_enable", 32'(push_enable), 32'(m_push()));
    chk("data_enable", 32'(data_enable), 32'(sending));
    chk("data", 32'(data), 32'(exp_data));
    chk("packet_dropped", 32'(packet_dropped), 32'(rx_data_valid && m_open() && m_full()));
    chk("packet_count", 32'(packet_count), 32'(npk));
    if (packet_dropped) drops_seen++;
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic put(logic [7:0] b, logic last);
    rx_data_valid = 1'b1; rx_data = b; rx_data_last = last;
    tick();
    rx_data_valid = 1'b0; rx_data_last = 1'b0;
  endtask

  task automatic send_pkt(int len, logic [7:0] base, int en_from);
    for (int i = 0; i < len; i++) begin
      enable = (i >= en_from);
      put(base + 8'(i), i == len - 1);
    end
  endtask

  task automatic idle(int n);
    rx_data_valid = 1'b0; rx_data_last = 1'b0;
    repeat (n) tick();
  endtask

  int d0;

  initial begin
    clock = 0; reset_n = 0; enable = 1; rx_data = 0;
    rx_data_valid = 0; rx_data_last = 0; data_ready = 0;
    cyc = 0; model_reset();
    #1;
    chk("rst_push", 32'(push_enable), 0);
    chk("rst_de", 32'(data_enable), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_drop", 32'(packet_dropped), 0);
    chk("rst_count", 32'(packet_count), 0);
    @(negedge clock); @(negedge clock);
    reset_n = 1;

    // T1: 3-byte packet, then read with the full quiet gap
    rdy_pol = 0;
    send_pkt(3, 8'hA0, 0);
    #1 chk("t1_count", 32'(packet_count), 1);
    chk("t1_push", 32'(push_enable), 1);
    chk("t1_de_low", 32'(data_enable), 0);
    tick();
    #1 chk("t1_de", 32'(data_enable), 1);
    chk("t1_a0", 32'(data), 32'h A0);
    rdy_pol = 1;
    tick();
    #1 chk("t1_a1", 32'(data), 32'h A1);
    tick();
    #1 chk("t1_a2", 32'(data), 32'h A2);
    tick();
    rdy_pol = 0;
    for (int i = 0; i < GAP; i++) begin
      #1 chk("t1_gap", 32'(push_enable | data_enable), 0);
      tick();
    end
    chk("t1_count0", 32'(packet_count), 0);

    // T2: two 1-byte packets, exact gap before the second is offered
    put(8'h11, 1); put(8'h22, 1);
    #1 chk("t2_count", 32'(packet_count), 2);
    chk("t2_d11", 32'(data), 32'h11);
    rdy_pol = 1; tick(); rdy_pol = 0;
    for (int i = 0; i < GAP; i++) begin
      #1 chk("t2_gap", 32'(push_enable), 0);
      tick();
    end
    #1 chk("t2_push", 32'(push_enable), 1);
    tick();
    #1 chk("t2_d22", 32'(data), 32'h22);
    rdy_pol = 1; tick(); rdy_pol = 0;
    idle(GAP + 2);

    // T3: overflow drops the oversize packet, committed data survives
    send_pkt(2, 8'hB0, 0);
    d0 = drops_seen;
    send_pkt(5, 8'hC0, 0);
    #1 chk("t3_count", 32'(packet_count), 1);
    chk("t3_drops", 32'(drops_seen - d0), 1);
    send_pkt(2, 8'hD0, 0);
    #1 chk("t3_count2", 32'(packet_count), 2);
    rdy_pol = 1; idle(70);
    chk("t3_drain", 32'(packet_count), 0);

    // T4: disabled start is skipped silently; next packet stored
    d0 = drops_seen;
    send_pkt(3, 8'hE0, 99);
    #1 chk("t4_none", 32'(packet_count), 0);
    send_pkt(4, 8'hF0, 2);
    send_pkt(2, 8'h60, 0);
    #1 chk("t4_count", 32'(packet_count), 1);
    chk("t4_nodrop", 32'(drops_seen - d0), 0);
    idle(30);

    // T5: commit in the same cycle as the last-byte read
    rdy_pol = 3; data_ready = 0;
    put(8'h55, 1); put(8'h56, 0);
    data_ready = 1; put(8'h57, 1); data_ready = 0;
    #1 chk("t5_count", 32'(packet_count), 1);
    rdy_pol = 1; idle(30);
    chk("t5_drain", 32'(packet_count), 0);

    // T6: asynchronous reset mid-send and mid-receive
    rdy_pol = 0;
    send_pkt(2, 8'h70, 0);
    idle(2);
    put(8'h80, 0);
    rx_data_valid = 1; rx_data = 8'h81;
    reset_n = 0;
    #1 chk("t6_push", 32'(push_enable), 0);
    chk("t6_de", 32'(data_enable), 0);
    chk("t6_data", 32'(data), 0);
    chk("t6_count", 32'(packet_count), 0);
    model_reset();
    rx_data_valid = 0;
    idle(2);
    reset_n = 1;
    rdy_pol = 1;
    send_pkt(3, 8'h90, 0);
    idle(30);
    chk("t6_after", 32'(packet_count), 0);

    // random traffic
    rdy_pol = 2;
    for (int n = 0; n < 2500; n++) begin
      enable        = ($urandom_range(0, 9) != 0);
      rx_data_valid = ($urandom_range(0, 9) < 6);
      rx_data       = 8'($urandom);
      rx_data_last  = ($urandom_range(0, 3) == 0);
      tick();
    end
    enable = 1; rdy_pol = 1;
    idle(300);
    chk("final_drain", 32'(packet_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
